// File: rtl/jk_pkg.sv
// ----------------------------------------------------------------------------
// jk_pkg
// Shared types for the JK command sequencer:
//   jk_op_e      - {j,k} encoding of a cell operation
//   jk_seq_st_e  - sequencer FSM state
//   jk_cmd_t     - one queued command (op + repeat count)
//   jk_ref_q     - reference-model next-q for a given op
// ----------------------------------------------------------------------------
package jk_pkg;

    localparam int JK_CNT_W = 4;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_CLR  = 2'b01,
        OP_SET  = 2'b10,
        OP_TGL  = 2'b11
    } jk_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } jk_seq_st_e;

    typedef struct packed {
        jk_op_e                op;
        logic [JK_CNT_W-1:0]   rpt;
    } jk_cmd_t;

    // Expected JK cell output after one sampling edge with the given op applied.
    function automatic logic jk_ref_q(input jk_op_e op, input logic q);
        case (op)
            OP_SET:  return 1'b1;
            OP_CLR:  return 1'b0;
            OP_TGL:  return ~q;
            default: return q;
        endcase
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// ----------------------------------------------------------------------------
// jk_cmd_fifo
// Synchronous DEPTH x W command FIFO with full/empty flags.
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset (flushes pointers)
//   i_push   - write request (ignored while full)
//   i_data   - write data
//   i_pop    - read request (ignored while empty)
//   o_data   - head entry (valid while !o_empty)
//   o_full   - no free entry
//   o_empty  - no stored entry
// ----------------------------------------------------------------------------
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_push;
    logic         w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// jk_cmd_sequencer
// Accepts {op,rpt} commands over valid/ready, queues them, and drives a JK
// cell's j/k with each op for rpt+1 cycles. A reference model tracks the
// expected cell q and mismatches against q_fb are flagged and counted.
// j/k change on posedge; the cell samples on negedge.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | j=k=0; pop the FIFO head as soon as one is visible
//   ST_ISSUE | drive op; count remain down; on 0 pop next or go idle
//
// Ports:
//   clk, reset            - clock, async active-low reset
//   cmd_valid/cmd_ready   - command handshake (ready = FIFO not full)
//   cmd_op, cmd_rpt       - {j,k} op and extra hold cycles
//   j, k                  - JK cell inputs
//   q_fb                  - JK cell output
//   busy                  - FIFO non-empty or issuing
//   done                  - pulse on last issue cycle of a command
//   err_clr               - clears err/err_cnt
//   err, err_cnt          - sticky mismatch flag, saturating mismatch count
// ----------------------------------------------------------------------------
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = JK_CNT_W,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_rpt,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    output logic             busy,
    output logic             done,
    input  logic             err_clr,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W+1:0]  w_fifo_dout;
    logic              w_pop;
    jk_op_e            w_head_op;
    logic [CNT_W-1:0]  w_head_rpt;
    jk_op_e            w_drv_op;
    logic              w_exp_nxt;
    logic              w_exp_vld_nxt;
    logic              w_mism;

    jk_seq_st_e        r_state;
    jk_op_e            r_op;
    logic [CNT_W-1:0]  r_remain;
    logic              r_exp;
    logic              r_exp_vld;
    logic              r_chk_vld;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CNT_W + 2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (cmd_valid),
        .i_data  ({cmd_op, cmd_rpt}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign cmd_ready  = !w_fifo_full;
    assign busy       = !w_fifo_empty || (r_state == ST_ISSUE);
    assign w_head_op  = jk_op_e'(w_fifo_dout[CNT_W+1:CNT_W]);
    assign w_head_rpt = w_fifo_dout[CNT_W-1:0];

    // Pop from idle, or on the last cycle of the current command.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == ST_IDLE) || (r_remain == '0));

    // Op that j/k will carry after this edge; the reference model follows it
    // so that exp describes q after the cell's next negedge.
    assign w_drv_op = w_pop ? w_head_op :
                      ((r_state == ST_ISSUE) && (r_remain != '0)) ? r_op :
                      OP_HOLD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_HOLD;
            r_remain <= '0;
            j        <= 1'b0;
            k        <= 1'b0;
            done     <= 1'b0;
        end else begin
            j <= w_drv_op[1];
            k <= w_drv_op[0];
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (w_pop) begin
                        r_state  <= ST_ISSUE;
                        r_op     <= w_head_op;
                        r_remain <= w_head_rpt;
                        done     <= (w_head_rpt == '0);
                    end
                end
                ST_ISSUE: begin
                    if (r_remain != '0) begin
                        r_remain <= r_remain - 1'b1;
                        done     <= (r_remain == CNT_W'(1));
                    end else if (w_pop) begin
                        r_op     <= w_head_op;
                        r_remain <= w_head_rpt;
                        done     <= (w_head_rpt == '0);
                    end else begin
                        r_state <= ST_IDLE;
                        r_op    <= OP_HOLD;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign w_exp_nxt     = jk_ref_q(w_drv_op, r_exp);
    assign w_exp_vld_nxt = r_exp_vld || (w_drv_op == OP_SET) || (w_drv_op == OP_CLR);
    assign w_mism        = r_chk_vld && (q_fb != r_exp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exp     <= 1'b0;
            r_exp_vld <= 1'b0;
            r_chk_vld <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            r_exp     <= w_exp_nxt;
            r_exp_vld <= w_exp_vld_nxt;
            r_chk_vld <= w_exp_vld_nxt;
            // A mismatch in the clearing cycle survives the clear.
            if (err_clr) begin
                err     <= w_mism;
                err_cnt <= w_mism ? ERR_W'(1) : '0;
            end else if (w_mism) begin
                err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_jk_cmd_sequencer
// Drives jk_cmd_sequencer into a behavioural JK cell (negedge sampled) and
// checks handshake, timing, done ordering, reference checking and reset.
// Accepted commands push their op onto a scoreboard; each done pulse pops it
// and compares against j/k.
// ----------------------------------------------------------------------------
module tb_jk_cmd_sequencer;

    localparam logic [1:0] L_HOLD = 2'b00;
    localparam logic [1:0] L_CLR  = 2'b01;
    localparam logic [1:0] L_SET  = 2'b10;
    localparam logic [1:0] L_TGL  = 2'b11;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_rpt;
    logic       j;
    logic       k;
    logic       q_fb;
    logic       busy;
    logic       done;
    logic       err_clr;
    logic       err;
    logic [7:0] err_cnt;

    logic       q_cell;
    logic       force_en;
    logic       force_val;

    int         n_chk;
    int         n_err;
    int         done_cnt;
    logic [1:0] sb_q[$];

    jk_cmd_sequencer #(.DEPTH(4), .CNT_W(4), .ERR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rpt   (cmd_rpt),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .busy      (busy),
        .done      (done),
        .err_clr   (err_clr),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // JK cell
    always @(negedge clk or negedge reset) begin
        if (!reset) q_cell <= 1'b0;
        else begin
            case ({j, k})
                2'b10:   q_cell <= 1'b1;
                2'b01:   q_cell <= 1'b0;
                2'b11:   q_cell <= ~q_cell;
                default: q_cell <= q_cell;
            endcase
        end
    end
    assign q_fb = force_en ? force_val : q_cell;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer
    always @(posedge clk) begin
        #1;
        if (reset && done) begin
            done_cnt++;
            chk_eq("sb_nonempty_on_done", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) chk_eq("sb_jk_on_done", {j, k}, sb_q.pop_front());
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [3:0] rpt, output int waited);
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rpt   = rpt;
        while (!cmd_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        chk_eq("send_ready_within_bound", 32'(cmd_ready), 1);
        @(posedge clk);
        sb_q.push_back(op);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((busy || sb_q.size() != 0) && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq("idle_busy", 32'(busy), 0);
        chk_eq("idle_sb_drained", sb_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        cycles(2);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        int nt;
        int last_done;
        int busy_drop;
        int dc0;
        logic qp;

        n_chk = 0; n_err = 0; done_cnt = 0;
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rpt = 4'd0;
        err_clr = 1'b0; force_en = 1'b0; force_val = 1'b0;

        // Reset state
        #12;
        chk_eq("rst_cmd_ready", 32'(cmd_ready), 1);
        chk_eq("rst_busy", 32'(busy), 0);
        chk_eq("rst_done", 32'(done), 0);
        chk_eq("rst_jk", {j, k}, 2'b00);
        chk_eq("rst_err", 32'(err), 0);
        chk_eq("rst_err_cnt", err_cnt, 0);
        @(negedge clk); reset = 1'b1;
        cycles(2);

        // 1: SET then CLR back-to-back
        send(L_SET, 4'd0, w);
        send(L_CLR, 4'd0, w);
        chk_eq("t1_jk_set", {j, k}, 2'b10);
        chk_eq("t1_done_set", 32'(done), 1);
        cycles(1);
        chk_eq("t1_jk_clr", {j, k}, 2'b01);
        chk_eq("t1_done_clr", 32'(done), 1);
        chk_eq("t1_q_after_set", 32'(q_fb), 1);
        cycles(1);
        chk_eq("t1_jk_idle", {j, k}, 2'b00);
        chk_eq("t1_done_idle", 32'(done), 0);
        chk_eq("t1_q_after_clr", 32'(q_fb), 0);
        chk_eq("t1_busy", 32'(busy), 0);
        chk_eq("t1_err", 32'(err), 0);

        // 2: SET then TGL rpt=3
        send(L_SET, 4'd0, w);
        send(L_TGL, 4'd3, w);
        qp = q_fb; nt = 0; last_done = -1; busy_drop = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (q_fb != qp) nt++;
            qp = q_fb;
            if (done) last_done = i;
            if (!busy && busy_drop < 0 && last_done >= 0) busy_drop = i;
        end
        chk_eq("t2_q_transitions", nt, 5);
        chk_eq("t2_q_final", 32'(q_fb), 1);
        chk_eq("t2_last_done_cycle", last_done, 4);
        chk_eq("t2_busy_drop_after_done", busy_drop - last_done, 1);
        chk_eq("t2_err_cnt", err_cnt, 0);

        // 3: fill FIFO behind a long ISSUE
        send(L_SET, 4'd15, w);
        send(L_CLR, 4'd0, w);
        send(L_SET, 4'd1, w);
        send(L_TGL, 4'd0, w);
        send(L_HOLD, 4'd0, w);
        chk_eq("t3_ready_when_full", 32'(cmd_ready), 0);
        send(L_SET, 4'd0, w);
        chk_eq("t3_fifth_wait_cycles", w, 13);
        wait_idle(200);
        chk_eq("t3_err_cnt", err_cnt, 0);

        // 4: forced mismatches, clear interaction, saturation
        send(L_SET, 4'd0, w);
        wait_idle(50);
        force_val = 1'b0; force_en = 1'b1;
        cycles(3);
        chk_eq("t4_err", 32'(err), 1);
        chk_eq("t4_err_cnt_3", err_cnt, 3);
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0; force_en = 1'b0;
        chk_eq("t4_clr_with_mism_err", 32'(err), 1);
        chk_eq("t4_clr_with_mism_cnt", err_cnt, 1);
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        chk_eq("t4_clr_alone_err", 32'(err), 0);
        chk_eq("t4_clr_alone_cnt", err_cnt, 0);
        force_en = 1'b1;
        cycles(300);
        force_en = 1'b0;
        chk_eq("t4_sat_cnt", err_cnt, 8'hFF);
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        chk_eq("t4_sat_cleared", err_cnt, 0);

        // 5: TGL first after reset, wrong q, no checking yet
        do_reset();
        force_val = 1'b0; force_en = 1'b1;
        send(L_TGL, 4'd2, w);
        cycles(10);
        chk_eq("t5_err", 32'(err), 0);
        chk_eq("t5_err_cnt", err_cnt, 0);
        chk_eq("t5_sb_drained", sb_q.size(), 0);
        force_en = 1'b0;

        // 6: reset mid-ISSUE with queued commands
        do_reset();
        send(L_SET, 4'd7, w);
        send(L_CLR, 4'd0, w);
        send(L_TGL, 4'd0, w);
        chk_eq("t6_jk_issue", {j, k}, 2'b10);
        cycles(1);
        dc0 = done_cnt;
        #2 reset = 1'b0;
        sb_q.delete();
        #1;
        chk_eq("t6_async_jk", {j, k}, 2'b00);
        chk_eq("t6_async_busy", 32'(busy), 0);
        chk_eq("t6_async_done", 32'(done), 0);
        @(negedge clk); reset = 1'b1;
        cycles(12);
        chk_eq("t6_no_done", done_cnt - dc0, 0);
        chk_eq("t6_busy_after", 32'(busy), 0);
        chk_eq("t6_ready_after", 32'(cmd_ready), 1);
        chk_eq("t6_jk_after", {j, k}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
